wrr_pkt_scheduler: RTL and testbench
====================================

# wrr_pkt_scheduler

Packet-aware weighted round-robin scheduler that shares one downstream beat port between CHANNELS requesters. Each requester owns whole packets, and a grant is never split mid-packet. A channel keeps its grant for up to `weight` consecutive packets, then the grant rotates. The block sits between the per-channel request/last sources and the single shared output stage, and uses the same weight-per-channel scheme as the existing arbiter.

## Interface
Parameters:
- `CHANNELS`, 8, number of requesters.
- `WEIGHT_W`, 4, bits per weight field. Weights range 0..15; the codebase weight limit is 16.
- `TIMEOUT`, 256, watchdog stall limit in cycles. Used only when the watchdog is compiled in.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `request`, in, CHANNELS: per-channel beat valid. It is held high until that channel's last beat is accepted.
- `last`, in, CHANNELS: per-channel end-of-packet flag, qualified by `request`.
- `weight`, in, CHANNELS*WEIGHT_W: packed weights. Channel i occupies `[i*WEIGHT_W +: WEIGHT_W]`.
- `out_ready`, in, 1: downstream accepts a beat.
- `grant`, out, CHANNELS: one-hot registered grant, or all zero.
- `out_valid`, out, 1: `|(grant & request)`, combinational from the registered grant.
- `out_last`, out, 1: `|(grant & request & last)`.
- `busy`, out, 1: high whenever state is not IDLE.

## Operation
- Eligible channel: `request[i]==1` and `weight[i]!=0`. A channel with weight 0 is never granted.
- State IDLE:
  - If any channel is eligible, pick the first eligible channel searching upward from `ptr` with wrap (ptr, ptr+1, ..., CHANNELS-1, 0, ...).
  - Register its one-hot grant, load `credit <= weight[sel]`, and go to XFER.
  - If no channel is eligible, stay in IDLE with `grant=0`.
- State XFER:
  - A beat transfers when `out_valid && out_ready`.
  - Non-last beat: no state change.
  - Last beat: `credit <= credit-1`.
  - If `credit-1 != 0`, stay in XFER with the grant unchanged. The next packet may start the following cycle.
  - If `credit-1 == 0`:
    - set `ptr <= sel+1` (mod CHANNELS);
    - clear `grant`;
    - go to IDLE.
- Weight is sampled only at grant time. Weight changes during XFER are ignored until the next grant.
- Request drops mid-packet (protocol violation): the grant is held and `out_valid` is 0. Without the watchdog the block waits indefinitely.
- Request low at a packet boundary while credit remains: the grant is held. The channel may start its next packet later. The watchdog is the only forced release.
- `credit` is WEIGHT_W bits wide. It never underflows because it is loaded non-zero and decremented only while non-zero.
- Reset values:
  - `grant=0`
  - `out_valid=0`
  - `out_last=0`
  - `busy=0`
  - `ptr=0`
  - `credit=0`
  - state IDLE
- Reset asserted mid-packet aborts the grant on the next edge. No beat is counted on that edge.

## Timing
- Request eligible at cycle N in IDLE: `grant` is valid at N+1, and `out_valid` is high from N+1 if the request is still high.
- Last beat accepted at cycle M that exhausts credit:
  - `grant=0` at M+1 (IDLE);
  - the next grant appears at M+2, giving one bubble cycle per rotation.
- Last beat accepted at cycle M with credit remaining: the same channel may transfer again at M+1, with no bubble.
- Single-beat packet: `request` and `last` are high in the same cycle. This is legal and consumes one credit.
- Only one state transition per cycle. The grant decision never looks at the current cycle's transfer.

## Configuration
- Macro: `WRR_SCHED_WATCHDOG_EN`.
- When defined:
  - a counter clears on every accepted beat and on every new grant, and increments each XFER cycle without a beat;
  - reaching `TIMEOUT` forces `ptr <= sel+1`, `grant <= 0`, and state IDLE, exactly as if credit were exhausted;
  - a one-cycle `timeout_pulse` output, 1 bit, reset 0, is added.
- When undefined: no counter, no `timeout_pulse` port, and no forced release.

## Structure
- Package `wrr_sched_pkg` holds:
  - the state enum `{IDLE, XFER}`;
  - `PTR_W = $clog2(CHANNELS)`;
  - the default `WEIGHT_W`, `CHANNELS`, and `TIMEOUT` constants.
- Sub-module `rr_pick`: a combinational rotating-priority picker. Inputs are the eligible mask and `ptr`. Outputs are one-hot `sel_oh`, binary `sel`, and `any`.
- The top level holds the FSM, `ptr`, `credit`, and the optional watchdog.

## Test plan
- Reset, then `request=8'h00` for 10 cycles: `grant=0`, `out_valid=0`, `busy=0` throughout.
- `request=8'h05`, all weights 1, single-beat packets, `out_ready=1`: grants alternate ch0, ch2, ch0, ch2, with one idle cycle between grants.
- ch1 weight 3 and ch4 weight 1, continuous 2-beat packets on both: the sequence is 3 ch1 packets (6 beats, no bubbles), then 1 ch4 packet, then repeat.
- ch3 weight 0 and ch5 weight 2, both requesting: ch3 is never granted and ch5 is granted repeatedly.
- `out_ready=0` mid-packet for 20 cycles: grant held, no credit change, and the packet completes once ready returns.
- With `WRR_SCHED_WATCHDOG_EN` and `TIMEOUT=16`, ch2 drops `request` mid-packet: at cycle 16 of the stall `timeout_pulse=1`, and the grant moves to the next eligible channel 2 cycles later.

Source files
------------

// File: rtl/wrr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wrr_sched_pkg
// Description : Shared types and constants for the packet-aware weighted
//               round-robin scheduler. Provides the scheduler state encoding,
//               default configuration values and a pointer-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wrr_sched_pkg;

    localparam int DEF_CHANNELS = 8;
    localparam int DEF_WEIGHT_W = 4;
    localparam int DEF_TIMEOUT  = 256;
    localparam int PTR_W        = $clog2(DEF_CHANNELS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    // Pointer width for an arbitrary channel count; a single channel still
    // needs a one-bit pointer so that vectors never collapse to zero width.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : wrr_sched_pkg
`default_nettype wire

// File: rtl/wrr_pkt_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority picker. Finds the first set
//               bit of the eligible mask searching upward from ptr with wrap.
// Ports       : eligible_i [CHANNELS] - candidate mask
//               ptr_i      [SEL_W]    - highest-priority position
//               sel_oh_o   [CHANNELS] - one-hot winner (zero if none)
//               sel_o      [SEL_W]    - binary winner index
//               any_o                 - at least one candidate present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import wrr_sched_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = ptr_width(DEF_CHANNELS)
) (
    input  logic [CHANNELS-1:0] eligible_i,
    input  logic [SEL_W-1:0]    ptr_i,
    output logic [CHANNELS-1:0] sel_oh_o,
    output logic [SEL_W-1:0]    sel_o,
    output logic                any_o
);

    always_comb begin
        logic             w_found;
        logic [SEL_W-1:0] w_idx;
        sel_oh_o = '0;
        sel_o    = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            // ptr is always < CHANNELS, so the modulo gives the wrapped slot
            w_idx = SEL_W'((int'(ptr_i) + k) % CHANNELS);
            if (!w_found && eligible_i[w_idx]) begin
                w_found         = 1'b1;
                sel_oh_o[w_idx] = 1'b1;
                sel_o           = w_idx;
            end
        end
        any_o = w_found;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/wrr_pkt_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : wrr_pkt_scheduler
// Description : Packet-aware weighted round-robin scheduler. Shares one beat
//               port between CHANNELS requesters; a granted channel keeps the
//               port for up to weight[i] whole packets, then the grant rotates.
//               A packet is never split.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               request [CHANNELS]  - per-channel beat valid
//               last    [CHANNELS]  - per-channel end-of-packet flag
//               weight  [CH*WW]     - packed weights, channel i at [i*WW +: WW]
//               out_ready           - downstream accepts a beat
//               grant   [CHANNELS]  - registered one-hot grant (or zero)
//               out_valid/out_last  - granted channel's request / last
//               busy                - scheduler not idle
//               timeout_pulse       - watchdog release strobe (watchdog only)
// Config      : WRR_SCHED_WATCHDOG_EN - adds a stall watchdog that forces the
//               grant to rotate after TIMEOUT cycles without a beat, plus the
//               timeout_pulse output.
// Revision    : 1.0 - initial release
// ============================================================================
module wrr_pkt_scheduler
    import wrr_sched_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          request,
    input  logic [CHANNELS-1:0]          last,
    input  logic [CHANNELS*WEIGHT_W-1:0] weight,
    input  logic                         out_ready,
    output logic [CHANNELS-1:0]          grant,
    output logic                         out_valid,
    output logic                         out_last,
    output logic                         busy
`ifdef WRR_SCHED_WATCHDOG_EN
    ,
    output logic                         timeout_pulse
`endif
);

    localparam int c_PTR_W = ptr_width(CHANNELS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                r_state_q,  w_state_d;
    logic [CHANNELS-1:0]   r_grant_q,  w_grant_d;
    logic [c_PTR_W-1:0]    r_sel_q,    w_sel_d;
    logic [c_PTR_W-1:0]    r_ptr_q,    w_ptr_d;
    logic [WEIGHT_W-1:0]   r_credit_q, w_credit_d;

    // ------------------------------------------------------------------
    // Per-channel weight unpacking and eligibility
    // ------------------------------------------------------------------
    logic [WEIGHT_W-1:0]   w_weight [CHANNELS];
    logic [CHANNELS-1:0]   w_eligible;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign w_weight[g]   = weight[g*WEIGHT_W +: WEIGHT_W];
        assign w_eligible[g] = request[g] && (w_weight[g] != '0);
    end

    logic [CHANNELS-1:0]   w_pick_oh;
    logic [c_PTR_W-1:0]    w_pick_sel;
    logic                  w_pick_any;

    rr_pick #(
        .CHANNELS (CHANNELS),
        .SEL_W    (c_PTR_W)
    ) u_rr_pick (
        .eligible_i (w_eligible),
        .ptr_i      (r_ptr_q),
        .sel_oh_o   (w_pick_oh),
        .sel_o      (w_pick_sel),
        .any_o      (w_pick_any)
    );

    // ------------------------------------------------------------------
    // Output stage: valid/last follow the registered grant directly
    // ------------------------------------------------------------------
    logic w_beat;
    logic w_release;
    logic [c_PTR_W-1:0] w_ptr_next;

    assign out_valid = |(r_grant_q & request);
    assign out_last  = |(r_grant_q & request & last);
    assign grant     = r_grant_q;
    assign busy      = (r_state_q != IDLE);
    assign w_beat    = out_valid && out_ready;

    assign w_ptr_next = (r_sel_q == c_PTR_W'(CHANNELS - 1)) ? '0 : r_sel_q + 1'b1;

    // ------------------------------------------------------------------
    // Optional stall watchdog
    // ------------------------------------------------------------------
`ifdef WRR_SCHED_WATCHDOG_EN
    localparam int c_WD_W = $clog2(TIMEOUT + 1);

    logic [c_WD_W-1:0] r_wd_cnt_q, w_wd_cnt_d;
    logic              r_tmo_q;
    logic              w_wd_fire;

    // Fires on the TIMEOUT-th consecutive XFER cycle without a beat
    assign w_wd_fire = (r_state_q == XFER) && !w_beat &&
                       (r_wd_cnt_q == c_WD_W'(TIMEOUT - 1));

    always_comb begin
        w_wd_cnt_d = r_wd_cnt_q;
        if ((r_state_q != XFER) || w_beat || w_wd_fire) begin
            w_wd_cnt_d = '0;
        end else begin
            w_wd_cnt_d = r_wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt_q <= '0;
            r_tmo_q    <= 1'b0;
        end else begin
            r_wd_cnt_q <= w_wd_cnt_d;
            r_tmo_q    <= w_wd_fire;
        end
    end

    assign timeout_pulse = r_tmo_q;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_grant_d  = r_grant_q;
        w_sel_d    = r_sel_q;
        w_ptr_d    = r_ptr_q;
        w_credit_d = r_credit_q;
        w_release  = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (w_pick_any) begin
                    w_grant_d  = w_pick_oh;
                    w_sel_d    = w_pick_sel;
                    // Weight is sampled here only; later changes wait for
                    // the next grant.
                    w_credit_d = w_weight[w_pick_sel];
                    w_state_d  = XFER;
                end
            end

            XFER: begin
                if (w_beat && out_last) begin
                    w_credit_d = r_credit_q - 1'b1;
                    if (r_credit_q == WEIGHT_W'(1)) begin
                        w_release = 1'b1;
                    end
                end
`ifdef WRR_SCHED_WATCHDOG_EN
                if (w_wd_fire) begin
                    w_release = 1'b1;
                end
`endif
                // Release always goes through IDLE, which gives the single
                // bubble cycle per rotation.
                if (w_release) begin
                    w_ptr_d   = w_ptr_next;
                    w_grant_d = '0;
                    w_state_d = IDLE;
                end
            end

            default: begin
                w_grant_d = '0;
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= IDLE;
            r_grant_q  <= '0;
            r_sel_q    <= '0;
            r_ptr_q    <= '0;
            r_credit_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_grant_q  <= w_grant_d;
            r_sel_q    <= w_sel_d;
            r_ptr_q    <= w_ptr_d;
            r_credit_q <= w_credit_d;
        end
    end

endmodule : wrr_pkt_scheduler
`default_nettype wire

// File: tb/tb_wrr_pkt_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_wrr_pkt_scheduler
// Description : Self-checking bench for wrr_pkt_scheduler. Directed checks for
//               reset, rotation bubbles and back-pressure; randomized rounds
//               whose accepted-beat order is predicted by a packet-level
//               round-robin model and checked by a scoreboard monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wrr_pkt_scheduler;

    localparam int CH   = 8;
    localparam int WW   = 4;
    localparam int ROT  = 5;
    localparam int PMAX = 128;

    logic            clk = 1'b0;
    logic            reset;
    logic [CH-1:0]   request;
    logic [CH-1:0]   last;
    logic [CH*WW-1:0] weight;
    logic            out_ready;
    logic [CH-1:0]   grant;
    logic            out_valid;
    logic            out_last;
    logic            busy;
`ifdef WRR_SCHED_WATCHDOG_EN
    logic            timeout_pulse;
`endif

    wrr_pkt_scheduler #(
        .CHANNELS (CH),
        .WEIGHT_W (WW),
        .TIMEOUT  (256)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .request   (request),
        .last      (last),
        .weight    (weight),
        .out_ready (out_ready),
        .grant     (grant),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy)
`ifdef WRR_SCHED_WATCHDOG_EN
        ,
        .timeout_pulse (timeout_pulse)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        bit lst;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    plen [CH][PMAX];
    int    didx [CH];
    int    pos  [CH];
    int    wts  [CH];
    bit    active = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int oh2idx(input logic [CH-1:0] g);
        int idx = -1;
        for (int i = 0; i < CH; i++) begin
            if (g[i]) idx = (idx == -1) ? i : -2;
        end
        return idx;
    endfunction

    function automatic logic [CH*WW-1:0] pack_weights();
        logic [CH*WW-1:0] v = '0;
        for (int i = 0; i < CH; i++) v[i*WW +: WW] = WW'(wts[i]);
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Source driver: random back-pressure, advances packet state per beat
    // ------------------------------------------------------------------
    initial begin
        bit pend;
        int pch;
        forever begin
            @(negedge clk);
            if (active) begin
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                pend = out_valid && out_ready;
                pch  = oh2idx(grant);
                @(posedge clk);
                #1;
                if (pend && pch >= 0) begin
                    pos[pch]++;
                    if (pos[pch] == plen[pch][didx[pch]]) begin
                        pos[pch] = 0;
                        if (didx[pch] < PMAX - 1) didx[pch]++;
                    end
                    last[pch] = (pos[pch] == plen[pch][didx[pch]] - 1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard monitor: every accepted beat must match the next expected
    // ------------------------------------------------------------------
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (active && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", oh2idx(grant), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_channel", oh2idx(grant), e.ch);
                    check("beat_last", int'(out_last), int'(e.lst));
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        request   = '0;
        last      = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Randomized round: model predicts the beat order from packet-level
    // round-robin rules, starting at pointer 0 after reset.
    // ------------------------------------------------------------------
    task automatic run_round(input logic [CH-1:0] mask, input int fixed_len);
        int midx [CH];
        int p;
        int sel;
        int cyc;
        do_reset();
        for (int i = 0; i < CH; i++) begin
            midx[i] = 0;
            didx[i] = 0;
            pos[i]  = 0;
            for (int k = 0; k < PMAX; k++)
                plen[i][k] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
        end
        p = 0;
        for (int r = 0; r < ROT; r++) begin
            sel = -1;
            for (int k = 0; k < CH; k++) begin
                int c;
                c = (p + k) % CH;
                if (sel < 0 && mask[c] && wts[c] != 0) sel = c;
            end
            for (int n = 0; n < wts[sel]; n++) begin
                int len;
                len = plen[sel][midx[sel]];
                midx[sel]++;
                for (int b = 0; b < len; b++) exp_q.push_back('{sel, (b == len - 1)});
            end
            p = (sel + 1) % CH;
        end
        @(negedge clk);
        weight = pack_weights();
        for (int i = 0; i < CH; i++) last[i] = (plen[i][0] == 1);
        request = mask;
        @(posedge clk);
        active = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        active = 1'b0;
        check("round_drained", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        out_ready = 1'b0;
        request   = '0;
    endtask

    initial begin
        logic [CH-1:0] alt_exp [8];
        logic [CH-1:0] mask;
        bit            ok;

        reset = 1'b1; request = '0; last = '0; weight = '0; out_ready = 1'b0;
        for (int i = 0; i < CH; i++) wts[i] = 0;

        // Reset state with no requests
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_grant", int'(grant), 0);
            check("idle_out_valid", int'(out_valid), 0);
            check("idle_busy", int'(busy), 0);
        end

        // ch0/ch2 weight 1, single-beat packets: alternate with one bubble
        for (int i = 0; i < CH; i++) wts[i] = 1;
        weight = pack_weights();
        request = 8'h05; last = 8'h05; out_ready = 1'b1;
        alt_exp = '{8'h01, 8'h00, 8'h04, 8'h00, 8'h01, 8'h00, 8'h04, 8'h00};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("alt_grant", int'(grant), int'(alt_exp[k]));
            check("alt_busy", int'(busy), int'(alt_exp[k] != 0));
        end

        // Back-pressure mid-packet: ch3 weight 2 held through a 20-cycle stall
        do_reset();
        for (int i = 0; i < CH; i++) wts[i] = 0;
        wts[3] = 2;
        weight = pack_weights();
        request = 8'h08; last = 8'h00; out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("stall_grant", int'(grant), 8'h08);
            check("stall_out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_nonlast_grant", int'(grant), 8'h08);
        last = 8'h08;
        @(negedge clk);
        check("stall_credit_left", int'(grant), 8'h08);
        @(negedge clk);
        check("stall_credit_done", int'(grant), 0);
        check("stall_busy_done", int'(busy), 0);
        out_ready = 1'b0; request = '0; last = '0;

        // ch1 weight 3, ch4 weight 1, 2-beat packets
        for (int i = 0; i < CH; i++) wts[i] = 0;
        wts[1] = 3; wts[4] = 1;
        run_round(8'h12, 2);

        // ch3 weight 0 never granted, ch5 weight 2
        for (int i = 0; i < CH; i++) wts[i] = 0;
        wts[5] = 2;
        run_round(8'h28, 0);

        // Random masks and weights, some weights zero
        for (int r = 0; r < 6; r++) begin
            do begin
                mask = CH'($urandom);
                ok = 1'b0;
                for (int i = 0; i < CH; i++) begin
                    wts[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
                    if (mask[i] && wts[i] != 0) ok = 1'b1;
                end
            end while (!ok);
            run_round(mask, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule : tb_wrr_pkt_scheduler
`default_nettype wire
